data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port 16x16 data memory between two requesters:
//  port A (CPU datapath load/store) and port B (test loader / DMA).
//  Sequences each access as a fixed 3-state FSM and drives the memory's
//  MemWrite/MemRead/Address/WriteData. Captures ReadData and returns it
//  to the winning port. Sits between the datapath and Data_Memory.
// PARAMETERS
//  DATA_W  16  data width (memory word)
//  ADDR_W  16  address width
//  DEPTH   16  implemented words; addr >= DEPTH is out of range
//  RR_EN   1   1 = round-robin between A/B; 0 = fixed priority, A wins
// PORTS
//  clk        in   1       single clock, all state on posedge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  req_a      in   1       port A request; hold with cmd until gnt_a
//  we_a       in   1       port A 1 = write, 0 = read
//  addr_a     in   ADDR_W  port A address
//  wdata_a    in   DATA_W  port A write data
//  req_b/we_b/addr_b/wdata_b  same as port A, for port B
//  gnt_a      out  1       1-cycle pulse: A's command accepted
//  gnt_b      out  1       1-cycle pulse: B's command accepted
//  rvalid_a   out  1       1-cycle pulse: rdata valid for A's read
//  rvalid_b   out  1       1-cycle pulse: rdata valid for B's read
//  rdata      out  DATA_W  read data, shared; qualified by rvalid_x
//  err        out  1       with rvalid_x/ack: access was out of range
//  busy       out  1       FSM not in IDLE
//  mem_write  out  1       to memory MemWrite
//  mem_read   out  1       to memory MemRead
//  mem_addr   out  ADDR_W  to memory Address
//  mem_wdata  out  DATA_W  to memory WriteData
//  mem_rdata  in   DATA_W  from memory ReadData
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0, FSM=IDLE, rr pointer=B-last,
//   so A wins first tie. In-flight op is discarded; a write in ACCESS
//   may or may not land; requester must reissue.
//  FSM: IDLE -> ACCESS -> CAPTURE -> IDLE; one op per 3 cycles.
//  IDLE: on posedge with any req: pick winner, latch we/addr/wdata,
//   pulse gnt_x, go ACCESS. No req: stay. Only IDLE samples req.
//  Tie (req_a & req_b): RR_EN=1 -> port not granted last; RR_EN=0 -> A.
//   Pointer updates only on grant.
//  ACCESS (1 cycle): mem_addr=latched addr; mem_write=we, mem_read=~we;
//   both strobes 0 if addr>=DEPTH. mem_wdata=latched wdata.
//  CAPTURE (1 cycle): strobes 0, mem_addr held. At exiting edge, read:
//   rdata<=mem_rdata (or 0 if out of range); rvalid_x pulses in the
//   following IDLE cycle. Write: no rvalid.
//  err: pulses with rvalid_x (read) or in the same cycle a write would
//   have completed (first IDLE after CAPTURE), only when out of range.
//  Latency: req sampled at edge N -> gnt_x high cycle N+1 -> strobe
//   cycle N+1 -> rvalid_x/rdata cycle N+3.
//  Back-to-back: a new req may be granted in the IDLE cycle rvalid
//   is high; rdata held until next read capture.
//  req dropped before grant: no effect. Command changed before grant:
//   value at the granting edge is used.
//  Never both mem_write and mem_read; never both gnt_a and gnt_b.
// TESTING
//  1 reset=0 mid-ACCESS -> strobes/gnt/rvalid/busy 0 at once;
//    after release, A+B tie -> gnt_a first.
//  2 A read addr 2 (mem=0x0006) -> gnt_a cyc1, mem_read cyc1,
//    rvalid_a cyc3, rdata=0x0006.
//  3 B write addr 5 = 0xBEEF, then B read addr 5 -> rvalid_b,
//    rdata=0xBEEF, err=0.
//  4 A and B held high for 6 grants, RR_EN=1 -> A,B,A,B,A,B;
//    RR_EN=0 -> A six times.
//  5 A read addr 16 -> no mem_read pulse; rvalid_a with rdata=0, err=1.
//  6 Random A/B traffic vs reference model -> no double strobes,
//    every gnt matched by exactly one completion, data matches.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Requester/memory bus bundle for data_mem_arbiter.
// slave = arbiter view, master = requesters, mem = memory side.
interface data_mem_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, err, busy,
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, err, busy
  );

  modport mem (
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: IDLE -> ACCESS -> CAPTURE,
// one access per three cycles, read data returned to the granted port.
module data_mem_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter bit          RR_EN  = 1'b1
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  logic   lat_we;
  logic   lat_oor;
  logic   own_b;
  logic   last_b;

  logic              pick_b_c;
  logic              any_req_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              oor_c;

  // Winner selection: on a tie, round-robin favours the port not granted last.
  always_comb begin
    pick_b_c = bus.req_b;
    if (bus.req_a && bus.req_b) begin
      pick_b_c = RR_EN ? !last_b : 1'b0;
    end
  end

  assign any_req_c   = bus.req_a | bus.req_b;
  assign sel_we_c    = pick_b_c ? bus.we_b    : bus.we_a;
  assign sel_addr_c  = pick_b_c ? bus.addr_b  : bus.addr_a;
  assign sel_wdata_c = pick_b_c ? bus.wdata_b : bus.wdata_a;
  assign oor_c       = (sel_addr_c >= ADDR_W'(DEPTH));

  // Access sequencer; pulses default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lat_we        <= 1'b0;
      lat_oor       <= 1'b0;
      own_b         <= 1'b0;
      last_b        <= 1'b1;
      bus.gnt_a     <= 1'b0;
      bus.gnt_b     <= 1'b0;
      bus.rvalid_a  <= 1'b0;
      bus.rvalid_b  <= 1'b0;
      bus.rdata     <= '0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.gnt_a    <= 1'b0;
      bus.gnt_b    <= 1'b0;
      bus.rvalid_a <= 1'b0;
      bus.rvalid_b <= 1'b0;
      bus.err      <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            state         <= ACCESS;
            bus.busy      <= 1'b1;
            bus.gnt_a     <= !pick_b_c;
            bus.gnt_b     <= pick_b_c;
            own_b         <= pick_b_c;
            last_b        <= pick_b_c;
            lat_we        <= sel_we_c;
            lat_oor       <= oor_c;
            bus.mem_addr  <= sel_addr_c;
            bus.mem_wdata <= sel_wdata_c;
            bus.mem_write <= sel_we_c && !oor_c;
            bus.mem_read  <= !sel_we_c && !oor_c;
          end
        end
        ACCESS: begin
          state         <= CAPTURE;
          bus.mem_write <= 1'b0;
          bus.mem_read  <= 1'b0;
        end
        CAPTURE: begin
          // Memory read is asynchronous on the held address; sample it here.
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.err  <= lat_oor;
          if (!lat_we) begin
            bus.rdata    <= lat_oor ? '0 : bus.mem_rdata;
            bus.rvalid_a <= !own_b;
            bus.rvalid_b <= own_b;
          end
        end
        default: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.mem_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomized checks of data_mem_arbiter (round-robin and fixed-priority copies).
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [15:0] addr_a, wdata_a, addr_b, wdata_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) i1 ();
  data_mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) i0 ();

  assign i1.req_a = req_a;  assign i1.we_a = we_a;  assign i1.addr_a = addr_a;  assign i1.wdata_a = wdata_a;
  assign i1.req_b = req_b;  assign i1.we_b = we_b;  assign i1.addr_b = addr_b;  assign i1.wdata_b = wdata_b;
  assign i0.req_a = req_a;  assign i0.we_a = we_a;  assign i0.addr_a = addr_a;  assign i0.wdata_a = wdata_a;
  assign i0.req_b = req_b;  assign i0.we_b = we_b;  assign i0.addr_b = addr_b;  assign i0.wdata_b = wdata_b;

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .RR_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(i1));
  data_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .RR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(i0));

  // Asynchronous-read, synchronous-write 16x16 memories, preloaded with i*3.
  logic [15:0] mem1 [16];
  logic [15:0] mem0 [16];
  always @(posedge clk or negedge reset) begin
    if (!reset) for (int i = 0; i < 16; i++) mem1[i] <= 16'(i * 3);
    else if (i1.mem_write) mem1[i1.mem_addr[3:0]] <= i1.mem_wdata;
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) for (int i = 0; i < 16; i++) mem0[i] <= 16'(i * 3);
    else if (i0.mem_write) mem0[i0.mem_addr[3:0]] <= i0.mem_wdata;
  end
  assign i1.mem_rdata = mem1[i1.mem_addr[3:0]];
  assign i0.mem_rdata = mem0[i0.mem_addr[3:0]];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Invariants on both copies every cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("rr.one_strobe", 16'(i1.mem_write & i1.mem_read), 16'd0);
      chk("rr.one_gnt",    16'(i1.gnt_a & i1.gnt_b),        16'd0);
      chk("fp.one_strobe", 16'(i0.mem_write & i0.mem_read), 16'd0);
      chk("fp.one_gnt",    16'(i0.gnt_a & i0.gnt_b),        16'd0);
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".gnt_a"},     16'(i1.gnt_a),     16'd0);
    chk({tag, ".gnt_b"},     16'(i1.gnt_b),     16'd0);
    chk({tag, ".rvalid_a"},  16'(i1.rvalid_a),  16'd0);
    chk({tag, ".rvalid_b"},  16'(i1.rvalid_b),  16'd0);
    chk({tag, ".busy"},      16'(i1.busy),      16'd0);
    chk({tag, ".mem_write"}, 16'(i1.mem_write), 16'd0);
    chk({tag, ".mem_read"},  16'(i1.mem_read),  16'd0);
  endtask

  logic [15:0] ref_mem [16];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset.rdata",     i1.rdata,     16'd0);
    chk("reset.err",       16'(i1.err),  16'd0);
    chk("reset.mem_addr",  i1.mem_addr,  16'd0);
    chk("reset.mem_wdata", i1.mem_wdata, 16'd0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'(i * 3);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One isolated access on the round-robin copy with fixed-latency checks.
  task automatic run_op(input bit pb, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input bit exp_err, input string tag);
    bit inr;
    inr = (addr < 16'd16);
    if (pb) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
    else    begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
    @(posedge clk); @(negedge clk);
    chk({tag, ".gnt_a"},     16'(i1.gnt_a),     16'(!pb));
    chk({tag, ".gnt_b"},     16'(i1.gnt_b),     16'(pb));
    chk({tag, ".mem_write"}, 16'(i1.mem_write), 16'(we & inr));
    chk({tag, ".mem_read"},  16'(i1.mem_read),  16'(!we & inr));
    chk({tag, ".mem_addr"},  i1.mem_addr,       addr);
    if (we) chk({tag, ".mem_wdata"}, i1.mem_wdata, wdata);
    req_a = 1'b0;
    req_b = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, ".capture_strobes"}, 16'(i1.mem_write | i1.mem_read), 16'd0);
    chk({tag, ".capture_busy"},    16'(i1.busy), 16'd1);
    @(posedge clk); @(negedge clk);
    chk({tag, ".rvalid_a"}, 16'(i1.rvalid_a), 16'(!pb & !we));
    chk({tag, ".rvalid_b"}, 16'(i1.rvalid_b), 16'(pb & !we));
    chk({tag, ".err"},      16'(i1.err),      16'(exp_err));
    chk({tag, ".busy"},     16'(i1.busy),     16'd0);
    if (!we) chk({tag, ".rdata"}, i1.rdata, exp_rdata);
  endtask

  typedef struct {
    bit          pb;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt [10];

  // Random-traffic state
  bit          pa, pbv, wa, wb, win_b, w_we, w_inr, last_b_m;
  logic [15:0] aa, da, ab, db, w_addr, w_data, exp_rd;

  initial begin
    reset = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

    vt[0] = '{1'b0, 1'b0, 16'd2,      16'h0000, 16'h0006, 1'b0};
    vt[1] = '{1'b1, 1'b1, 16'd5,      16'hBEEF, 16'h0000, 1'b0};
    vt[2] = '{1'b1, 1'b0, 16'd5,      16'h0000, 16'hBEEF, 1'b0};
    vt[3] = '{1'b0, 1'b0, 16'd16,     16'h0000, 16'h0000, 1'b1};
    vt[4] = '{1'b0, 1'b1, 16'd20,     16'h1234, 16'h0000, 1'b1};
    vt[5] = '{1'b0, 1'b0, 16'd15,     16'h0000, 16'h002D, 1'b0};
    vt[6] = '{1'b1, 1'b0, 16'd0,      16'h0000, 16'h0000, 1'b0};
    vt[7] = '{1'b0, 1'b1, 16'd15,     16'hA5A5, 16'h0000, 1'b0};
    vt[8] = '{1'b1, 1'b0, 16'd15,     16'h0000, 16'hA5A5, 1'b0};
    vt[9] = '{1'b0, 1'b0, 16'hFFFF,   16'h0000, 16'h0000, 1'b1};

    do_reset();

    // Reset during ACCESS clears everything immediately; then a tie goes to A.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; addr_a = 16'd3;
    @(posedge clk); @(negedge clk);
    chk("midreset.pre_read", 16'(i1.mem_read), 16'd1);
    #2 reset = 1'b0;
    #1 chk_idle_outputs("midreset");
    req_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 16'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 16'd2;
    @(posedge clk); @(negedge clk);
    chk("tie.gnt_a", 16'(i1.gnt_a), 16'd1);
    chk("tie.gnt_b", 16'(i1.gnt_b), 16'd0);
    req_a = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("tie.rvalid_a", 16'(i1.rvalid_a), 16'd1);
    chk("tie.rdata_a",  i1.rdata,         16'h0003);
    @(posedge clk); @(negedge clk);
    chk("tie.gnt_b_next", 16'(i1.gnt_b), 16'd1);
    req_b = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("tie.rvalid_b", 16'(i1.rvalid_b), 16'd1);
    chk("tie.rdata_b",  i1.rdata,         16'h0006);

    // Table of single accesses, issued back to back.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      run_op(vt[k].pb, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].exp_rdata,
             vt[k].exp_err, $sformatf("vec%0d", k));
    end

    // Both ports held: round-robin alternates, fixed priority always picks A.
    do_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 16'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 16'd2;
    for (int g = 0; g < 6; g++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("rr%0d.gnt_a", g), 16'(i1.gnt_a), 16'((g % 2) == 0));
      chk($sformatf("rr%0d.gnt_b", g), 16'(i1.gnt_b), 16'((g % 2) == 1));
      chk($sformatf("fp%0d.gnt_a", g), 16'(i0.gnt_a), 16'd1);
      chk($sformatf("fp%0d.gnt_b", g), 16'(i0.gnt_b), 16'd0);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
    end
    req_a = 1'b0;
    req_b = 1'b0;

    // Random two-port traffic against a reference model (round-robin copy).
    do_reset();
    last_b_m = 1'b1;
    pa = 1'b0; pbv = 1'b0;
    wa = 1'b0; wb = 1'b0; aa = '0; da = '0; ab = '0; db = '0;
    for (int k = 0; k < 40; k++) begin
      if (!pa && ($urandom_range(0, 1) == 1)) begin
        pa = 1'b1; wa = 1'($urandom_range(0, 1));
        aa = 16'($urandom_range(0, 17)); da = 16'($urandom);
      end
      if (!pbv && ($urandom_range(0, 1) == 1)) begin
        pbv = 1'b1; wb = 1'($urandom_range(0, 1));
        ab = 16'($urandom_range(0, 17)); db = 16'($urandom);
      end
      if (!pa && !pbv) begin
        pa = 1'b1; wa = 1'b0; aa = 16'($urandom_range(0, 15)); da = '0;
      end
      req_a = pa; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = pbv; we_b = wb; addr_b = ab; wdata_b = db;
      @(posedge clk); @(negedge clk);
      win_b  = (pa && pbv) ? !last_b_m : pbv;
      w_we   = win_b ? wb : wa;
      w_addr = win_b ? ab : aa;
      w_data = win_b ? db : da;
      w_inr  = (w_addr < 16'd16);
      chk("rand.gnt_a",     16'(i1.gnt_a),     16'(!win_b));
      chk("rand.gnt_b",     16'(i1.gnt_b),     16'(win_b));
      chk("rand.mem_write", 16'(i1.mem_write), 16'(w_we & w_inr));
      chk("rand.mem_read",  16'(i1.mem_read),  16'(!w_we & w_inr));
      chk("rand.mem_addr",  i1.mem_addr,       w_addr);
      last_b_m = win_b;
      if (win_b) pbv = 1'b0; else pa = 1'b0;
      req_a = pa;
      req_b = pbv;
      // Loser may change its command while waiting; the granting-edge value counts.
      if (pa && ($urandom_range(0, 3) == 0)) begin aa = 16'($urandom_range(0, 17)); addr_a = aa; end
      if (pbv && ($urandom_range(0, 3) == 0)) begin db = 16'($urandom); wdata_b = db; end
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      exp_rd = w_inr ? ref_mem[w_addr[3:0]] : 16'd0;
      chk("rand.rvalid_a", 16'(i1.rvalid_a), 16'(!win_b & !w_we));
      chk("rand.rvalid_b", 16'(i1.rvalid_b), 16'(win_b & !w_we));
      chk("rand.err",      16'(i1.err),      16'(!w_inr));
      if (!w_we) chk("rand.rdata", i1.rdata, exp_rd);
      if (w_we && w_inr) ref_mem[w_addr[3:0]] = w_data;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
